// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: valid/allow-in pipeline register, RF read, prioritised bypass, stall.
// Optional build macro ID_STALL_CNT_EN adds stall/flush event counters.
module id_operand_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RIDX_W    = 5,
  parameter int unsigned NUM_FWD   = 3,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [PAYLOAD_W-1:0]      i_in_payload,
  input  logic [31:0]               i_in_inst,
  input  logic                      i_flush,
  output logic [RIDX_W-1:0]         o_rf_raddr1,
  output logic [RIDX_W-1:0]         o_rf_raddr2,
  input  logic [XLEN-1:0]           i_rf_rdata1,
  input  logic [XLEN-1:0]           i_rf_rdata2,
  input  logic                      i_rs1_en,
  input  logic                      i_rs2_en,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  input  logic [NUM_FWD-1:0]        i_fwd_pending,
  input  logic [NUM_FWD*RIDX_W-1:0] i_fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [31:0]               o_out_inst,
  output logic [PAYLOAD_W-1:0]      o_out_payload,
  output logic [XLEN-1:0]           o_out_rs1,
  output logic [XLEN-1:0]           o_out_rs2
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]               o_stall_cnt,
  output logic [31:0]               o_flush_cnt
`endif
);

  logic                 r_id_valid;
  logic [31:0]          r_inst;
  logic [PAYLOAD_W-1:0] r_payload;

  logic            w_stall;
  logic            w_in_ready;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_rs1_pend;
  logic            w_rs2_pend;

  assign o_rf_raddr1 = r_inst[15 +: RIDX_W];
  assign o_rf_raddr2 = r_inst[20 +: RIDX_W];

  // Scan from the oldest channel down so the youngest matching channel overrides.
  always_comb begin
    w_rs1_data = i_rf_rdata1;
    w_rs2_data = i_rf_rdata2;
    w_rs1_pend = 1'b0;
    w_rs2_pend = 1'b0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (i_fwd_valid[i] && i_fwd_we[i] && (i_fwd_addr[i*RIDX_W +: RIDX_W] == o_rf_raddr1)) begin
        w_rs1_data = i_fwd_data[i*XLEN +: XLEN];
        w_rs1_pend = i_fwd_pending[i];
      end
      if (i_fwd_valid[i] && i_fwd_we[i] && (i_fwd_addr[i*RIDX_W +: RIDX_W] == o_rf_raddr2)) begin
        w_rs2_data = i_fwd_data[i*XLEN +: XLEN];
        w_rs2_pend = i_fwd_pending[i];
      end
    end
    if (o_rf_raddr1 == '0) begin
      w_rs1_data = '0;
      w_rs1_pend = 1'b0;
    end
    if (o_rf_raddr2 == '0) begin
      w_rs2_data = '0;
      w_rs2_pend = 1'b0;
    end
  end

  assign w_stall    = r_id_valid & ((i_rs1_en & w_rs1_pend) | (i_rs2_en & w_rs2_pend));
  assign w_in_ready = ~r_id_valid | (~w_stall & i_out_ready);

  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = r_id_valid & ~w_stall;
  assign o_out_inst    = r_inst;
  assign o_out_payload = r_payload;
  assign o_out_rs1     = w_rs1_data;
  assign o_out_rs2     = w_rs2_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_id_valid <= 1'b0;
    end else if (i_flush) begin
      r_id_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_id_valid <= i_in_valid;
    end
  end

  // Data registers are deliberately unreset; they are qualified by r_id_valid.
  always_ff @(posedge i_clk) begin
    if (w_in_ready && i_in_valid && !i_flush) begin
      r_inst    <= i_in_inst;
      r_payload <= i_in_payload;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_flush && r_id_valid) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomised + directed bench for id_operand_stage against a behavioural reference model.
module tb_id_operand_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NF   = 3;
  localparam int PW   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, in_valid, in_ready, flush, rs1_en, rs2_en, out_valid, out_ready;
  logic [PW-1:0]    in_payload, out_payload;
  logic [31:0]      in_inst, out_inst;
  logic [RW-1:0]    rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]  rf_rdata1, rf_rdata2, out_rs1, out_rs2;
  logic [NF-1:0]    fwd_valid, fwd_we, fwd_pending;
  logic [NF*RW-1:0] fwd_addr;
  logic [NF*XLEN-1:0] fwd_data;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  id_operand_stage #(.XLEN(XLEN), .RIDX_W(RW), .NUM_FWD(NF), .PAYLOAD_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_payload(in_payload), .i_in_inst(in_inst), .i_flush(flush),
    .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .i_rs1_en(rs1_en), .i_rs2_en(rs2_en),
    .i_fwd_valid(fwd_valid), .i_fwd_we(fwd_we), .i_fwd_pending(fwd_pending),
    .i_fwd_addr(fwd_addr), .i_fwd_data(fwd_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_inst(out_inst),
    .o_out_payload(out_payload), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2)
`ifdef ID_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_valid;
  logic [31:0]   m_inst;
  logic [PW-1:0] m_pay;
  logic [31:0]   m_stall_cnt, m_flush_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // x0 reads zero; otherwise youngest matching producer, else register file.
  function automatic void resolve(input logic [4:0] r, input logic [31:0] rf,
                                  output logic [31:0] d, output bit p);
    d = rf;
    p = 1'b0;
    if (r == 5'd0) begin
      d = '0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (fwd_valid[i] && fwd_we[i] && fwd_addr[i*RW +: RW] == r) begin
        d = fwd_data[i*XLEN +: XLEN];
        p = fwd_pending[i];
        return;
      end
    end
  endfunction

  // Inputs are driven just after a negedge; check outputs, then advance one clock.
  task automatic step();
    logic [31:0] d1, d2;
    bit p1, p2, stall, e_ready;
    #1;
    resolve(m_inst[19:15], rf_rdata1, d1, p1);
    resolve(m_inst[24:20], rf_rdata2, d2, p2);
    stall   = m_valid && ((rs1_en && p1) || (rs2_en && p2));
    e_ready = !m_valid || (!stall && out_ready);
    check_eq("out_valid", 64'(out_valid), 64'(m_valid && !stall));
    check_eq("in_ready", 64'(in_ready), 64'(e_ready));
    if (m_valid) begin
      check_eq("out_inst", 64'(out_inst), 64'(m_inst));
      check_eq("out_payload", out_payload, m_pay);
      check_eq("rf_raddr1", 64'(rf_raddr1), 64'(m_inst[19:15]));
      check_eq("rf_raddr2", 64'(rf_raddr2), 64'(m_inst[24:20]));
      check_eq("out_rs1", 64'(out_rs1), 64'(d1));
      check_eq("out_rs2", 64'(out_rs2), 64'(d2));
    end
`ifdef ID_STALL_CNT_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (stall) m_stall_cnt = m_stall_cnt + 1;
      if (flush && m_valid) m_flush_cnt = m_flush_cnt + 1;
    end
    if (rst_n && e_ready && in_valid && !flush) begin
      m_inst = in_inst;
      m_pay  = in_payload;
    end
    if (!rst_n || flush) m_valid = 1'b0;
    else if (e_ready) m_valid = in_valid;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst_n = 1; in_valid = 0; in_inst = '0; in_payload = '0; flush = 0; out_ready = 0;
    rs1_en = 0; rs2_en = 0; fwd_valid = '0; fwd_we = '0; fwd_pending = '0;
    fwd_addr = '0; fwd_data = '0; rf_rdata1 = '0; rf_rdata2 = '0;
  endtask

  task automatic load(input logic [31:0] inst);
    clear_inputs();
    in_valid = 1; in_inst = inst; in_payload = {$urandom, $urandom}; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
  endtask

  task automatic set_fwd(input int ch, input bit v, input bit pend, input logic [4:0] a,
                         input logic [31:0] d);
    fwd_valid[ch] = v; fwd_we[ch] = v; fwd_pending[ch] = pend;
    fwd_addr[ch*RW +: RW] = a; fwd_data[ch*XLEN +: XLEN] = d;
  endtask

  task automatic rand_inputs();
    rst_n      = ($urandom_range(0, 99) != 0);
    in_valid   = ($urandom_range(0, 3) != 0);
    in_inst    = $urandom;
    in_inst[19:15] = 5'($urandom_range(0, 3));
    in_inst[24:20] = 5'($urandom_range(0, 3));
    in_payload = {$urandom, $urandom};
    flush      = ($urandom_range(0, 9) == 0);
    out_ready  = ($urandom_range(0, 3) != 0);
    rs1_en     = 1'($urandom);
    rs2_en     = 1'($urandom);
    fwd_valid  = NF'($urandom);
    fwd_we     = NF'($urandom | $urandom);
    fwd_pending = NF'($urandom & $urandom);
    for (int i = 0; i < NF; i++) begin
      fwd_addr[i*RW +: RW]     = 5'($urandom_range(0, 3));
      fwd_data[i*XLEN +: XLEN] = $urandom;
    end
    rf_rdata1 = $urandom;
    rf_rdata2 = $urandom;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    m_valid = 0; m_inst = '0; m_pay = '0; m_stall_cnt = 0; m_flush_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();  // reset state check with rst_n still low

    // addi x1,x0,5 then hand-off
    load(32'h0050_0093);
    out_ready = 1; step();

    // rs1=x3 with ch0/ch2 both matching, then drop them in turn
    load(32'h0001_8093);
    rs1_en = 1; rf_rdata1 = 32'h11;
    set_fwd(0, 1, 0, 5'd3, 32'hAA);
    set_fwd(2, 1, 0, 5'd3, 32'hCC);
    step();
    set_fwd(0, 0, 0, 5'd3, 32'hAA); step();
    set_fwd(2, 0, 0, 5'd3, 32'hCC); step();
    // shadowed pending on ch1 must not stall
    set_fwd(0, 1, 0, 5'd3, 32'h77); set_fwd(1, 1, 1, 5'd3, 32'h55); step();

    // rs2=x5 pending on ch0 for one cycle
    load(32'h0050_00B3);
    rs2_en = 1; out_ready = 1;
    set_fwd(0, 1, 1, 5'd5, 32'h1234);
    step();
    set_fwd(0, 1, 0, 5'd5, 32'h1234); step();

    // same with rs2_en=0, then rd=x0 pending match
    load(32'h0050_00B3);
    rs2_en = 0; set_fwd(0, 1, 1, 5'd5, 32'h1234); step();
    load(32'h0000_00B3);
    rs1_en = 1; rs2_en = 1; set_fwd(0, 1, 1, 5'd0, 32'hDEAD); step();

    // held inst, out_ready=0, flush with incoming
    load(32'h0020_8113);
    step();
    flush = 1; in_valid = 1; in_inst = 32'h0030_0193; step();
    flush = 0; in_valid = 0; step();

    // three stall cycles then a flush of the held instruction
    load(32'h0001_8093);
    rs1_en = 1; set_fwd(0, 1, 1, 5'd3, 32'h9);
    repeat (3) step();
    flush = 1; step();
    clear_inputs(); step();
    rst_n = 0; step();
    rst_n = 1; step();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
